pos_func_eval: RTL and testbench
================================

Name: pos_func_eval

Overview:
Parametrised product-of-sums evaluator for an N_IN-input Boolean function.
- The function is defined by a runtime-programmable maxterm mask: out_f is 0 exactly when mask bit [in_vec] is 1.
- Mode 1: streaming evaluation with a valid/ready handshake.
- Mode 2: sweep. Walks every input combination in order, streams the full truth table and counts the ones.
- Sits between the stimulus source and the result checker in the logic-function test fabric.

Parameters:
- N_IN, 4, number of function inputs (2..8).
- MASK_RST, 16'h5507, maxterm mask loaded at reset (width 2**N_IN). The default encodes maxterms 0,1,2,8,10,12,14.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  load cfg_mask into the mask register
- cfg_mask  in  2**N_IN  new maxterm mask; bit i=1 means F(i)=0
- in_valid  in  1  input vector valid
- in_ready  out  1  evaluator accepts in_vec
- in_vec  in  N_IN  input combination; MSB is the first variable (A)
- sweep_start  in  1  pulse; begin exhaustive sweep
- sweep_busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse after the last sweep result is accepted
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_f  out  1  function value
- out_idx  out  N_IN  input combination that produced out_f
- ones_count  out  N_IN+1  number of F=1 results in the last completed sweep

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising edge.
- Reset values:
  - mask=MASK_RST; out_valid=0; out_f=0; out_idx=0
  - sweep_busy=0; sweep_done=0; ones_count=0
  - state=IDLE
- Output stage is a single register.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - A transfer occurs when in_valid && in_ready.
  - Latency: result appears one cycle after transfer: out_f = ~mask[in_vec], out_idx = in_vec.
  - Full throughput with out_ready held high.
- out_valid is held and out_f/out_idx are stable while out_valid && !out_ready.
- FSM states IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on sweep_start. Counter cnt cleared to 0, accumulator cleared to 0.
    - sweep_start has priority over a same-cycle in_valid; the input is not accepted because in_ready is already 0 from that edge.
    - If out_valid is pending when sweep_start arrives, the pending result drains first; sweep results follow it in order.
  - SWEEP: whenever the output register is free (!out_valid || out_ready), load out_f=~mask[cnt], out_idx=cnt, add out_f to the accumulator, and increment cnt.
    - After loading cnt = 2**N_IN-1, go to DONE.
  - DONE: wait until the last result is accepted (out_valid && out_ready). Then ones_count = accumulator, sweep_done=1 for one cycle, go to IDLE.
- sweep_busy=1 in SWEEP and DONE.
- sweep_start in SWEEP or DONE is ignored.
- cfg_we:
  - Takes effect the next cycle in IDLE.
  - Ignored in SWEEP/DONE, so the mask is frozen during a sweep.
  - cfg_we in the same cycle as an input transfer: the transfer uses the old mask.
- The accumulator is N_IN+1 bits wide, so a value of 2**N_IN does not wrap. cnt is N_IN bits and stops at its max; it never wraps.
- ones_count holds its value until the next sweep completes. It is unchanged by aborted sweeps and cleared only by reset.
- Reset mid-sweep: everything returns to reset values on that edge, including mask=MASK_RST. No sweep_done is issued.

Decomposition:
- Package pos_eval_pkg:
  - state enum {IDLE, SWEEP, DONE}
  - the default mask constant
  - a width helper function for 2**N_IN
- One natural sub-module: pos_out_reg, the single-entry valid/ready output register carrying f and idx. It is used by both the streaming and sweep paths.

Test Plan:
- Reset, default mask, out_ready=1. in_vec 4'h0, then 4'h3, then 4'hE. Required: out_f 0,1,0 with out_idx 0,3,E, each one cycle after its transfer.
- sweep_start with default mask and out_ready=1. Required: 16 results with idx 0..15; F=1 only at 3,4,5,6,7,9,11,13,15; ones_count=9; sweep_done pulses once; sweep_busy for 17 cycles.
- Backpressure during sweep, out_ready toggling 1010…. Required: no idx skipped or duplicated; out_f/out_idx stable while stalled; ones_count=9.
- cfg_we with mask 16'h0000, then sweep. Required: all out_f=1 and ones_count=16 (N_IN+1 width, no wrap). Separately, cfg_we asserted mid-sweep must be ignored.
- Streaming input in_vec=5 pending with out_ready=0, then sweep_start. Required: idx 5 is delivered before sweep idx 0; in_ready stays 0 until IDLE.
- rst_n=0 at sweep idx 7. Required: next cycle out_valid=0, sweep_busy=0, no sweep_done, ones_count=0, mask=16'h5507.

Source files
------------

// File: rtl/pos_eval_pkg.sv
// Shared types and constants for the product-of-sums function evaluator.
// Holds the FSM state type, the default maxterm mask and a mask-width helper.
package pos_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Maxterms 0,1,2,8,10,12,14 for the default 4-input function
    localparam logic [15:0] MASK_DEFAULT = 16'h5507;

    function automatic int mask_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/pos_out_reg.sv
// Single-entry valid/ready output register carrying a function value and its index.
// Loads only when free; holds data stable while the consumer stalls.
module pos_out_reg #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             f_in,
    input  logic [IDX_W-1:0] idx_in,
    input  logic             out_ready,
    output logic             out_free,
    output logic             out_valid,
    output logic             out_f,
    output logic [IDX_W-1:0] out_idx
);

    logic             valid_q, valid_d;
    logic             f_q, f_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign out_free  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_f     = f_q;
    assign out_idx   = idx_q;

    always_comb begin
        valid_d = valid_q;
        f_d     = f_q;
        idx_d   = idx_q;
        if (load) begin
            valid_d = 1'b1;
            f_d     = f_in;
            idx_d   = idx_in;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            f_q     <= 1'b0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            f_q     <= f_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/pos_func_eval.sv
// Product-of-sums evaluator: out_f is 0 exactly where the maxterm mask bit is set.
// Streams single evaluations or sweeps the whole truth table and counts the ones.
module pos_func_eval
    import pos_eval_pkg::*;
#(
    parameter int                             N_IN     = 4,
    parameter logic [mask_width(N_IN)-1:0]    MASK_RST = MASK_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    input  logic [mask_width(N_IN)-1:0] cfg_mask,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_IN-1:0]             in_vec,
    input  logic                        sweep_start,
    output logic                        sweep_busy,
    output logic                        sweep_done,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_f,
    output logic [N_IN-1:0]             out_idx,
    output logic [N_IN:0]               ones_count
);

    localparam int              W       = mask_width(N_IN);
    localparam logic [N_IN-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [W-1:0]      mask_q, mask_d;
    logic [N_IN-1:0]   cnt_q, cnt_d;
    logic [N_IN:0]     acc_q, acc_d;
    logic [N_IN:0]     ones_q, ones_d;
    logic              done_q, done_d;

    logic              load;
    logic              f_in;
    logic [N_IN-1:0]   idx_in;
    logic              out_free;

    pos_out_reg #(.IDX_W(N_IN)) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .f_in      (f_in),
        .idx_in    (idx_in),
        .out_ready (out_ready),
        .out_free  (out_free),
        .out_valid (out_valid),
        .out_f     (out_f),
        .out_idx   (out_idx)
    );

    assign sweep_busy = (state_q != IDLE);
    assign sweep_done = done_q;
    assign ones_count = ones_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        load    = 1'b0;
        f_in    = ~mask_q[in_vec];
        idx_in  = in_vec;
        // A same-cycle sweep_start wins, so the input is refused rather than dropped
        in_ready = (state_q == IDLE) && !sweep_start && out_free;

        unique case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    mask_d = cfg_mask;
                end
                if (sweep_start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (in_valid && in_ready) begin
                    load = 1'b1;
                end
            end
            SWEEP: begin
                f_in   = ~mask_q[cnt_q];
                idx_in = cnt_q;
                if (out_free) begin
                    load  = 1'b1;
                    acc_d = acc_q + {{N_IN{1'b0}}, f_in};
                    if (cnt_q == CNT_MAX) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    ones_d  = acc_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= MASK_RST;
            cnt_q   <= '0;
            acc_q   <= '0;
            ones_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_pos_func_eval.sv
// Self-checking bench for pos_func_eval: table-driven streaming vectors, scoreboarded
// sweeps, backpressure, mask reprogramming, drain-before-sweep and reset mid-sweep.
module tb_pos_func_eval;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [15:0] cfg_mask;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_vec;
    logic        sweep_start;
    logic        sweep_busy;
    logic        sweep_done;
    logic        out_valid;
    logic        out_ready;
    logic        out_f;
    logic [3:0]  out_idx;
    logic [4:0]  ones_count;

    typedef struct packed {
        logic [3:0] idx;
        logic       f;
    } res_t;

    typedef struct {
        logic [3:0] vec;
        logic       f;
    } vec_t;

    res_t        exp_q[$];
    vec_t        tbl[6];
    logic [15:0] model_mask;
    int          errors = 0;
    int          checks = 0;
    int          done_pulses = 0;
    int          busy_cycles = 0;
    bit          stall_prev = 1'b0;
    logic [3:0]  prev_idx;
    logic        prev_f;

    pos_func_eval #(.N_IN(4), .MASK_RST(16'h5507)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_mask    (cfg_mask),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_f       (out_f),
        .out_idx     (out_idx),
        .ones_count  (ones_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer plus stall-stability and pulse/busy accounting
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_idx", out_idx, prev_idx);
                checkOutput("stall_f", out_f, prev_f);
            end
            stall_prev = out_valid && !out_ready;
            prev_idx   = out_idx;
            prev_f     = out_f;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_empty: got idx %0h required no result", out_idx);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    checkOutput("sb_idx", out_idx, e.idx);
                    checkOutput("sb_f", out_f, e.f);
                end
            end
            if (sweep_done) done_pulses++;
            if (sweep_busy) busy_cycles++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [3:0] vec, input logic f_exp);
        bit got = 1'b0;
        in_vec   = vec;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            if (in_ready) got = 1'b1;
            else tick();
        end
        checkOutput("in_ready_wait", got, 1);
        if (got) begin
            exp_q.push_back('{idx: vec, f: f_exp});
            tick();
            checkOutput("latency_valid", out_valid, 1);
            checkOutput("latency_idx", out_idx, vec);
        end
        in_valid = 1'b0;
    endtask

    task automatic setMask(input logic [15:0] m);
        cfg_mask   = m;
        cfg_we     = 1'b1;
        model_mask = m;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic startSweep();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back('{idx: 4'(i), f: ~model_mask[i]});
        end
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
    endtask

    task automatic waitSweepDone(input bit toggle, input bit check_ready);
        bit seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            tick();
            if (check_ready && sweep_busy) checkOutput("in_ready_busy", in_ready, 0);
            if (toggle) out_ready = ~out_ready;
            if (sweep_done) seen = 1'b1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("sweep_done_seen", seen, 1);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_mask = '0; in_valid = 1'b0; in_vec = '0;
        sweep_start = 1'b0; out_ready = 1'b1; model_mask = 16'h5507;
        tbl[0] = '{4'h0, 1'b0};
        tbl[1] = '{4'h3, 1'b1};
        tbl[2] = '{4'hE, 1'b0};
        tbl[3] = '{4'h4, 1'b1};
        tbl[4] = '{4'h8, 1'b0};
        tbl[5] = '{4'hF, 1'b1};

        tick(); tick();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_f", out_f, 0);
        checkOutput("rst_out_idx", out_idx, 0);
        checkOutput("rst_busy", sweep_busy, 0);
        checkOutput("rst_done", sweep_done, 0);
        checkOutput("rst_ones", ones_count, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_in_ready", in_ready, 1);

        for (int i = 0; i < 6; i++) applyStimulus(tbl[i].vec, tbl[i].f);
        tick();

        busy_cycles = 0; done_pulses = 0;
        startSweep();
        waitSweepDone(1'b0, 1'b0);
        checkOutput("sweep_busy_cycles", busy_cycles, 17);
        checkOutput("sweep_done_pulses", done_pulses, 1);
        checkOutput("sweep_ones", ones_count, 9);
        checkOutput("sweep_sb_drained", exp_q.size(), 0);

        startSweep();
        waitSweepDone(1'b1, 1'b0);
        checkOutput("bp_ones", ones_count, 9);
        checkOutput("bp_sb_drained", exp_q.size(), 0);

        setMask(16'h0000);
        startSweep();
        waitSweepDone(1'b0, 1'b0);
        checkOutput("mask0_ones", ones_count, 16);

        startSweep();
        cfg_mask = 16'hFFFF;
        cfg_we   = 1'b1;
        tick();
        cfg_we = 1'b0;
        waitSweepDone(1'b0, 1'b0);
        checkOutput("midsweep_cfg_ones", ones_count, 16);
        applyStimulus(4'h3, 1'b1);
        tick();

        setMask(16'h5507);
        out_ready = 1'b0;
        applyStimulus(4'h5, 1'b1);
        startSweep();
        in_vec   = 4'h9;
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            checkOutput("pend_idx", out_idx, 5);
            checkOutput("pend_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        waitSweepDone(1'b0, 1'b1);
        checkOutput("pend_ones", ones_count, 9);
        checkOutput("pend_sb_drained", exp_q.size(), 0);

        done_pulses = 0;
        startSweep();
        begin
            bit hit = 1'b0;
            for (int n = 0; n < 100 && !hit; n++) begin
                if (out_valid && out_idx == 4'h7) hit = 1'b1;
                else tick();
            end
            checkOutput("reach_idx7", hit, 1);
        end
        rst_n = 1'b0;
        exp_q.delete();
        model_mask = 16'h5507;
        tick();
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_busy", sweep_busy, 0);
        checkOutput("midrst_done", sweep_done, 0);
        checkOutput("midrst_ones", ones_count, 0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        checkOutput("midrst_no_done", done_pulses, 0);
        applyStimulus(4'h0, 1'b0);
        applyStimulus(4'h3, 1'b1);
        applyStimulus(4'hA, 1'b0);
        tick(); tick();
        checkOutput("final_sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
